// File: rtl/chip_bus_mem_ctrl.sv
// Burst controller between the chip_bus cache and a single-port synchronous SRAM.
// Optional parity on the data paths is enabled with `define CHIP_BUS_MEM_PARITY_EN.
module chip_bus_mem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int BEATS       = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic              rdata_last,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef CHIP_BUS_MEM_PARITY_EN
  ,
  output logic              rdata_par,
  input  logic              wdata_par,
  output logic              par_err
`endif
);

  localparam int OFS_W  = $clog2(BEATS);
  localparam int WCNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, RESP, WDATA} state_t;

  localparam state_t BEAT_START = (WAIT_STATES > 0) ? WAIT : ACCESS;

  state_t              r_state;
  state_t              w_next;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [OFS_W-1:0]    r_beat;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic                r_mem_cs;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_resp_first;

  logic                w_accept;
  logic                w_wr_beat;
  logic                w_last_beat;
  logic                w_dir_write;
  logic [ADDR_W-1:0]   w_src_addr;
  logic [OFS_W-1:0]    w_src_beat;
  logic [OFS_W-1:0]    w_ofs;
  logic [ADDR_W-1:0]   w_beat_addr;

  assign w_accept    = req_valid && (r_state == IDLE);
  assign w_wr_beat   = (r_state == WDATA) && wdata_valid;
  assign w_last_beat = (r_beat == OFS_W'(BEATS - 1));
  assign w_dir_write = (r_state == IDLE) ? req_write : r_write;

  // From IDLE the first access may be issued straight from the request inputs.
  assign w_src_addr  = (r_state == IDLE) ? req_addr : r_addr;
  assign w_src_beat  = (r_state == IDLE) ? '0 : r_beat;
  assign w_ofs       = w_src_addr[OFS_W-1:0] + w_src_beat;
  assign w_beat_addr = {w_src_addr[ADDR_W-1:OFS_W], w_ofs};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_accept) w_next = req_write ? WDATA : BEAT_START;
      WAIT:   if (r_wait_cnt == WCNT_W'(WAIT_STATES - 1)) w_next = ACCESS;
      ACCESS: begin
        if (r_write) w_next = w_last_beat ? IDLE : WDATA;
        else         w_next = RESP;
      end
      RESP:   if (rdata_ready) w_next = w_last_beat ? IDLE : BEAT_START;
      WDATA:  if (wdata_valid) w_next = BEAT_START;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state      <= IDLE;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_beat       <= '0;
      r_wait_cnt   <= '0;
      r_mem_cs     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata      <= '0;
      r_resp_first <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_beat  <= '0;
      end else if (((r_state == RESP) && rdata_ready) ||
                   ((r_state == ACCESS) && r_write)) begin
        r_beat <= r_beat + 1'b1;
      end
      r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 1'b1 : '0;
      r_mem_cs   <= (w_next == ACCESS);
      r_mem_we   <= (w_next == ACCESS) && w_dir_write;
      if (w_next == ACCESS) r_mem_addr <= w_beat_addr;
      if (w_wr_beat) r_mem_wdata <= wdata;
      // SRAM data arrives in the first RESP cycle; it is held here for stalls.
      r_resp_first <= (w_next == RESP) && (r_state != RESP);
      if (r_resp_first) r_rdata <= mem_rdata;
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign wdata_ready = (r_state == WDATA);
  assign rdata_valid = (r_state == RESP);
  assign rdata_last  = (r_state == RESP) && w_last_beat;
  assign rdata       = r_resp_first ? mem_rdata : r_rdata;
  assign mem_cs      = r_mem_cs;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

`ifdef CHIP_BUS_MEM_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_par_err <= 1'b0;
    end else if (w_wr_beat && ((^wdata) != wdata_par)) begin
      r_par_err <= 1'b1;
    end
  end

  assign rdata_par = ^rdata;
  assign par_err   = r_par_err;
`endif

endmodule
